// File: rtl/arm_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// arm_multicycle_ctrl
//   Main controller for a multicycle ARM-subset datapath with a shared memory.
//   A registered FSM walks each instruction through FETCH/DECODE and then
//   memory, data-processing or branch states. It holds the NZCV flag register,
//   evaluates all 16 condition codes, waits on a memory-ready handshake with an
//   optional bus timeout, and reports undecodable instructions.
//
// Optional feature macro: ARM_CTRL_LINK_EN
//   defined   : BL (funct[4]=1 in BRANCH) also asserts link_write
//   undefined : link_write is tied low and BL behaves as a plain B
//
// Parameters
//   ALU_OP_W    alu_control width (0=ADD 1=SUB 2=AND 3=ORR)
//   TIMEOUT_CYC max cycles to wait for mem_ready, 0 = wait forever
//   CNT_W       timeout counter width (TIMEOUT_CYC < 2**CNT_W)
//
// Ports
//   clk, reset      rising-edge clock, synchronous active-high reset
//   i_cond/i_op/i_funct  instruction register fields [31:28]/[27:26]/[25:20]
//   i_alu_flags     NZCV produced by the ALU during the execute cycle
//   i_mem_ready     memory accepts/returns data this cycle
//   o_flags_q       registered NZCV
//   o_pc_write, o_ir_write, o_mem_write, o_reg_write, o_link_write  strobes
//   o_adr_src, o_result_src, o_alu_src_a, o_alu_src_b, o_imm_src,
//   o_reg_src, o_alu_control  datapath multiplexer / operation selects
//   o_illegal       one-cycle pulse in DECODE for an undecodable instruction
//   o_bus_err       one-cycle pulse when a handshake wait times out
// -----------------------------------------------------------------------------
module arm_multicycle_ctrl #(
  parameter int ALU_OP_W    = 2,
  parameter int TIMEOUT_CYC = 0,
  parameter int CNT_W       = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          i_cond,
  input  logic [1:0]          i_op,
  input  logic [5:0]          i_funct,
  input  logic [3:0]          i_alu_flags,
  input  logic                i_mem_ready,
  output logic [3:0]          o_flags_q,
  output logic                o_pc_write,
  output logic                o_ir_write,
  output logic                o_adr_src,
  output logic                o_mem_write,
  output logic [1:0]          o_result_src,
  output logic [1:0]          o_alu_src_a,
  output logic [1:0]          o_alu_src_b,
  output logic [1:0]          o_imm_src,
  output logic [1:0]          o_reg_src,
  output logic                o_reg_write,
  output logic                o_link_write,
  output logic [ALU_OP_W-1:0] o_alu_control,
  output logic                o_illegal,
  output logic                o_bus_err
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
    S_MEMWR, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
  } state_t;

  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t               r_state;
  logic [3:0]           r_flags;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_pc_write_br;
  logic                 r_adr_src;
  logic                 r_mem_write;
  logic [1:0]           r_result_src;
  logic [1:0]           r_alu_src_a;
  logic [1:0]           r_alu_src_b;
  logic [1:0]           r_imm_src;
  logic [1:0]           r_reg_src;
  logic                 r_reg_write;
  logic [ALU_OP_W-1:0]  r_alu_control;
`ifdef ARM_CTRL_LINK_EN
  logic                 r_link_write;
`endif

  // ---------------------------------------------------------------------------
  // Instruction decode
  // ---------------------------------------------------------------------------
  logic [3:0] w_cmd;
  logic       w_cmd_legal;
  logic       w_cmd_logic;
  logic [1:0] w_cmd_alu;
  logic       w_is_cmp;
  logic       w_is_mov;

  assign w_cmd    = i_funct[4:1];
  assign w_is_cmp = (w_cmd == 4'b1010);
  assign w_is_mov = (w_cmd == 4'b1101);

  always_comb begin
    w_cmd_legal = 1'b1;
    w_cmd_logic = 1'b0;
    w_cmd_alu   = 2'd0;
    case (w_cmd)
      4'b0100: w_cmd_alu = 2'd0;                          // ADD
      4'b0010: w_cmd_alu = 2'd1;                          // SUB
      4'b0000: begin w_cmd_alu = 2'd2; w_cmd_logic = 1'b1; end  // AND
      4'b1100: begin w_cmd_alu = 2'd3; w_cmd_logic = 1'b1; end  // ORR
      4'b1010: w_cmd_alu = 2'd1;                          // CMP is a SUB
      4'b1101: begin w_cmd_alu = 2'd0; w_cmd_logic = 1'b1; end  // MOV: 0 + op2
      default: w_cmd_legal = 1'b0;
    endcase
  end

  // Condition check: even codes test a base predicate, odd codes its inverse.
  // 1110 (AL) always passes; 1111 is reported as illegal separately.
  logic w_n, w_z, w_c, w_v;
  logic w_cond_base;
  logic w_cond_pass;

  assign {w_n, w_z, w_c, w_v} = r_flags;

  always_comb begin
    w_cond_base = 1'b1;
    case (i_cond[3:1])
      3'd0: w_cond_base = w_z;
      3'd1: w_cond_base = w_c;
      3'd2: w_cond_base = w_n;
      3'd3: w_cond_base = w_v;
      3'd4: w_cond_base = w_c & ~w_z;
      3'd5: w_cond_base = (w_n == w_v);
      3'd6: w_cond_base = ~w_z & (w_n == w_v);
      default: w_cond_base = 1'b1;
    endcase
  end

  assign w_cond_pass = (i_cond[3:1] == 3'b111) ? 1'b1 : (w_cond_base ^ i_cond[0]);

  logic w_decode_illegal;
  assign w_decode_illegal = (i_cond == 4'b1111) ||
                            (w_cond_pass && ((i_op == 2'b11) ||
                                             ((i_op == 2'b00) && !w_cmd_legal)));

  // ---------------------------------------------------------------------------
  // Handshake wait and timeout
  // ---------------------------------------------------------------------------
  logic w_is_wait;
  logic w_timeout;
  logic [CNT_W-1:0] w_cnt_next;

  assign w_is_wait = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  assign w_timeout = (TIMEOUT_CYC != 0) && w_is_wait && !i_mem_ready && (r_cnt == TO_LAST);

  // Counter only runs while stalled; any progress or timeout restarts it.
  always_comb begin
    w_cnt_next = '0;
    if ((TIMEOUT_CYC != 0) && w_is_wait && !i_mem_ready && !w_timeout)
      w_cnt_next = r_cnt + CNT_W'(1);
  end

  // ---------------------------------------------------------------------------
  // Next state and flag update
  // ---------------------------------------------------------------------------
  state_t     w_state_next;
  logic [3:0] w_flags_next;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_FETCH:  if (i_mem_ready) w_state_next = S_DECODE;
      S_DECODE: begin
        if (w_decode_illegal || !w_cond_pass) w_state_next = S_FETCH;
        else begin
          case (i_op)
            2'b01:   w_state_next = S_MEMADR;
            2'b00:   w_state_next = i_funct[5] ? S_EXECI : S_EXECR;
            2'b10:   w_state_next = S_BRANCH;
            default: w_state_next = S_FETCH;
          endcase
        end
      end
      S_MEMADR: w_state_next = i_funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (i_mem_ready)    w_state_next = S_MEMWB;
        else if (w_timeout) w_state_next = S_FETCH;
      end
      S_MEMWR:  if (i_mem_ready || w_timeout) w_state_next = S_FETCH;
      S_EXECR, S_EXECI: w_state_next = w_is_cmp ? S_FETCH : S_ALUWB;
      S_MEMWB, S_ALUWB, S_BRANCH: w_state_next = S_FETCH;
      default:  w_state_next = S_FETCH;
    endcase
  end

  // Logical ops (AND/ORR/MOV) leave C and V untouched.
  always_comb begin
    w_flags_next = r_flags;
    if (((r_state == S_EXECR) || (r_state == S_EXECI)) && (i_funct[0] || w_is_cmp)) begin
      if (w_cmd_logic) w_flags_next = {i_alu_flags[3:2], r_flags[1:0]};
      else             w_flags_next = i_alu_flags;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state, flags, counter and Moore outputs registered from next state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_FETCH;
      r_flags       <= 4'b0000;
      r_cnt         <= '0;
      r_pc_write_br <= 1'b0;
      r_adr_src     <= 1'b0;
      r_mem_write   <= 1'b0;
      r_result_src  <= 2'd0;
      r_alu_src_a   <= 2'd1;
      r_alu_src_b   <= 2'd2;
      r_imm_src     <= 2'd0;
      r_reg_src     <= 2'd0;
      r_reg_write   <= 1'b0;
      r_alu_control <= '0;
`ifdef ARM_CTRL_LINK_EN
      r_link_write  <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_next;
      r_flags       <= w_flags_next;
      r_cnt         <= w_cnt_next;
      r_pc_write_br <= 1'b0;
      r_adr_src     <= 1'b0;
      r_mem_write   <= 1'b0;
      r_result_src  <= 2'd0;
      r_alu_src_a   <= 2'd0;
      r_alu_src_b   <= 2'd0;
      r_imm_src     <= 2'd0;
      r_reg_src     <= 2'd0;
      r_reg_write   <= 1'b0;
      r_alu_control <= '0;
`ifdef ARM_CTRL_LINK_EN
      r_link_write  <= 1'b0;
`endif
      case (w_state_next)
        S_FETCH: begin
          r_alu_src_a <= 2'd1;
          r_alu_src_b <= 2'd2;
        end
        S_EXECR, S_EXECI: begin
          r_alu_src_a   <= w_is_mov ? 2'd2 : 2'd0;
          r_alu_src_b   <= (w_state_next == S_EXECI) ? 2'd1 : 2'd0;
          r_alu_control <= ALU_OP_W'(w_cmd_alu);
        end
        S_ALUWB: r_reg_write <= 1'b1;
        S_MEMADR: begin
          r_alu_src_b   <= 2'd1;
          r_imm_src     <= 2'd1;
          r_alu_control <= i_funct[3] ? ALU_OP_W'(0) : ALU_OP_W'(1);
        end
        S_MEMRD: r_adr_src <= 1'b1;
        S_MEMWB: begin
          r_reg_write  <= 1'b1;
          r_result_src <= 2'd1;
        end
        S_MEMWR: begin
          r_adr_src   <= 1'b1;
          r_mem_write <= 1'b1;
          r_reg_src   <= 2'b10;
        end
        S_BRANCH: begin
          r_alu_src_a   <= 2'd1;
          r_alu_src_b   <= 2'd1;
          r_imm_src     <= 2'd2;
          r_result_src  <= 2'd2;
          r_pc_write_br <= 1'b1;
`ifdef ARM_CTRL_LINK_EN
          r_link_write  <= i_funct[4];
`endif
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. Handshake-qualified strobes depend on this cycle's mem_ready;
  // every write strobe is suppressed while reset is asserted.
  // ---------------------------------------------------------------------------
  logic w_fetch_go;
  assign w_fetch_go = (r_state == S_FETCH) && i_mem_ready;

  assign o_flags_q     = r_flags;
  assign o_ir_write    = w_fetch_go & ~reset;
  assign o_pc_write    = (w_fetch_go | r_pc_write_br) & ~reset;
  assign o_adr_src     = r_adr_src;
  assign o_mem_write   = r_mem_write & ~reset;
  assign o_result_src  = r_result_src;
  assign o_alu_src_a   = r_alu_src_a;
  assign o_alu_src_b   = r_alu_src_b;
  assign o_imm_src     = r_imm_src;
  assign o_reg_src     = r_reg_src;
  assign o_reg_write   = r_reg_write & ~reset;
  assign o_alu_control = r_alu_control;
  assign o_illegal     = (r_state == S_DECODE) && w_decode_illegal && !reset;
  assign o_bus_err     = w_timeout & ~reset;
`ifdef ARM_CTRL_LINK_EN
  assign o_link_write  = r_link_write & ~reset;
`else
  assign o_link_write  = 1'b0;
`endif

endmodule
